// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch in T0-T2, per-class
// execute in T3-T7, memory steps stretched by mem_ready, with stop/idle and halt.
module control_sequencer #(
  parameter int                 OPC_W   = 5,
  parameter int                 ALUOP_W = 5,
  parameter logic [ALUOP_W-1:0] ALU_ADD = 5'b00011,
  parameter logic [ALUOP_W-1:0] ALU_SUB = 5'b00100,
  parameter logic [ALUOP_W-1:0] ALU_AND = 5'b00101,
  parameter logic [ALUOP_W-1:0] ALU_OR  = 5'b00110
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [31:0]        ir,
  input  logic               CON_out,
  input  logic               mem_ready,
  input  logic               stop,
  output logic               PCout,
  output logic               Zlowout,
  output logic               MDRout,
  output logic               MARin,
  output logic               Zin,
  output logic               PCin,
  output logic               MDRin,
  output logic               IRin,
  output logic               Yin,
  output logic               IncPC,
  output logic               Read,
  output logic               Write,
  output logic               GRA,
  output logic               GRB,
  output logic               GRC,
  output logic               Rin,
  output logic               Rout,
  output logic               BAout,
  output logic               Cout,
  output logic               CON_in,
  output logic [ALUOP_W-1:0] operation,
  output logic               run,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_RST, S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state, next_state;

  logic [OPC_W-1:0]   opc;
  logic               is_ld, is_ldi, is_st, is_br, is_nop, is_halt;
  logic               is_add, is_sub, is_and, is_or, is_addi, is_andi, is_ori;
  logic               is_reg, is_imm, is_bad;
  logic [ALUOP_W-1:0] alu_sel;
  state_t             enter_t0;
  logic               unused_ir_bits;

  assign opc            = ir[31 -: OPC_W];
  assign unused_ir_bits = ^ir[31-OPC_W:0];

  always_comb begin
    is_ld   = (opc == OPC_W'(5'b00000));
    is_ldi  = (opc == OPC_W'(5'b00001));
    is_st   = (opc == OPC_W'(5'b00010));
    is_add  = (opc == OPC_W'(5'b00011));
    is_sub  = (opc == OPC_W'(5'b00100));
    is_and  = (opc == OPC_W'(5'b00101));
    is_or   = (opc == OPC_W'(5'b00110));
    is_addi = (opc == OPC_W'(5'b01100));
    is_andi = (opc == OPC_W'(5'b01101));
    is_ori  = (opc == OPC_W'(5'b01110));
    is_br   = (opc == OPC_W'(5'b10010));
    is_nop  = (opc == OPC_W'(5'b11010));
    is_halt = (opc == OPC_W'(5'b11011));
    is_reg  = is_add | is_sub | is_and | is_or;
    is_imm  = is_addi | is_andi | is_ori;
    is_bad  = !(is_ld | is_ldi | is_st | is_reg | is_imm | is_br | is_nop | is_halt);
    if (is_sub)                 alu_sel = ALU_SUB;
    else if (is_and | is_andi)  alu_sel = ALU_AND;
    else if (is_or  | is_ori)   alu_sel = ALU_OR;
    else                        alu_sel = ALU_ADD;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_RST;
    else       state <= next_state;
  end

  // Every instruction boundary funnels through enter_t0 so stop is honoured uniformly.
  assign enter_t0 = stop ? S_IDLE : S_T0;

  always_comb begin
    next_state = state;
    unique case (state)
      S_RST:  next_state = enter_t0;
      S_IDLE: if (!stop) next_state = S_T0;
      S_T0:   next_state = S_T1;
      S_T1:   if (mem_ready) next_state = S_T2;
      S_T2: begin
        if (is_halt)              next_state = S_HALT;
        else if (is_nop | is_bad) next_state = enter_t0;
        else                      next_state = S_T3;
      end
      S_T3:   next_state = S_T4;
      S_T4:   next_state = S_T5;
      S_T5:   next_state = (is_ld | is_st | is_br) ? S_T6 : enter_t0;
      S_T6: begin
        if (is_ld)      next_state = mem_ready ? S_T7 : S_T6;
        else if (is_st) next_state = S_T7;
        else            next_state = enter_t0;
      end
      S_T7:   if (!(is_st && !mem_ready)) next_state = enter_t0;
      S_HALT: next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin  = 1'b0; Zin   = 1'b0;
    PCin  = 1'b0; MDRin   = 1'b0; IRin   = 1'b0; Yin    = 1'b0; IncPC = 1'b0;
    Read  = 1'b0; Write   = 1'b0; GRA    = 1'b0; GRB    = 1'b0; GRC   = 1'b0;
    Rin   = 1'b0; Rout    = 1'b0; BAout  = 1'b0; Cout   = 1'b0; CON_in = 1'b0;
    operation = '0;
    illegal   = 1'b0;
    run       = !(state inside {S_RST, S_IDLE, S_HALT});
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; operation = ALU_ADD; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; illegal = is_bad; end
      S_T3: begin
        if (is_br) begin
          GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1;
        end else if (is_reg | is_imm) begin
          GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ld | is_ldi | is_st) begin
          GRB = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end
      end
      S_T4: begin
        if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end else if (is_reg) begin
          GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = alu_sel;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; operation = alu_sel;
        end else if (is_ld | is_ldi | is_st) begin
          Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD;
        end
      end
      S_T5: begin
        if (is_br) begin
          Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD;
        end else if (is_ld | is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_reg | is_imm | is_ldi) begin
          Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = CON_out;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          MDRout = 1'b1; Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the hand-derived strobe
// word for each cycle, a negedge monitor pops and compares it against the DUT.
module tb_control_sequencer;

  logic        Clock, Reset, CON_out, mem_ready, stop;
  logic [31:0] ir;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
  logic Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout, CON_in;
  logic [4:0] operation;
  logic run, illegal;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .ir(ir), .CON_out(CON_out), .mem_ready(mem_ready),
    .stop(stop), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Cout(Cout), .CON_in(CON_in),
    .operation(operation), .run(run), .illegal(illegal)
  );

  localparam logic [19:0] PCOUT = 20'd1 << 19, ZLOWOUT = 20'd1 << 18, MDROUT = 20'd1 << 17,
                          MARIN = 20'd1 << 16, ZIN     = 20'd1 << 15, PCIN   = 20'd1 << 14,
                          MDRIN = 20'd1 << 13, IRIN    = 20'd1 << 12, YIN    = 20'd1 << 11,
                          INCPC = 20'd1 << 10, READ    = 20'd1 << 9,  WRITE  = 20'd1 << 8,
                          GRA_B = 20'd1 << 7,  GRB_B   = 20'd1 << 6,  GRC_B  = 20'd1 << 5,
                          RIN   = 20'd1 << 4,  ROUT    = 20'd1 << 3,  BAOUT  = 20'd1 << 2,
                          COUT  = 20'd1 << 1,  CONIN   = 20'd1 << 0;
  localparam logic [19:0] NONE = 20'd0;
  localparam logic [4:0]  OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101,
                          OP_OR = 5'b00110, OP_0 = 5'b00000;

  typedef struct {
    string       name;
    logic [26:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [26:0] obs;

  assign obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
                Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout, CON_in,
                operation, run, illegal};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got strobes=%h op=%b run=%b ill=%b, expected strobes=%h op=%b run=%b ill=%b",
               name, act[26:7], act[6:2], act[1], act[0],
               exp_v[26:7], exp_v[6:2], exp_v[1], exp_v[0]);
    end
  endtask

  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, obs, e.v);
    end
  end

  // One call = one clock cycle of expected Moore outputs, inputs already applied.
  task automatic step(input string name, input logic [19:0] s, input logic [4:0] op,
                      input logic r, input logic ill);
    exp_t e;
    e.name = name;
    e.v    = {s, op, r, ill};
    sb.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input logic ill);
    step("T0", PCOUT | MARIN | INCPC | ZIN, OP_ADD, 1'b1, 1'b0);
    step("T1", ZLOWOUT | PCIN | READ | MDRIN, OP_0, 1'b1, 1'b0);
    step("T2", MDROUT | IRIN, OP_0, 1'b1, ill);
  endtask

  task automatic addr_calc();
    step("base_T3", GRB_B | ROUT | BAOUT | YIN, OP_0, 1'b1, 1'b0);
    step("base_T4", COUT | ZIN, OP_ADD, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ir = 32'h0A000054; mem_ready = 1'b1; stop = 1'b0; CON_out = 1'b0; Reset = 1'b1;
    @(posedge Clock);
    #1;
    repeat (3) step("reset", NONE, OP_0, 1'b0, 1'b0);
    Reset = 1'b0;
    step("reset_release", NONE, OP_0, 1'b0, 1'b0);

    // ldi, zero wait
    fetch(1'b0);
    addr_calc();
    step("ldi_T5", ZLOWOUT | GRA_B | RIN, OP_0, 1'b1, 1'b0);

    // ld with 2 wait cycles in T1 and 3 in T6
    ir = 32'h00000000;
    step("ld_T0", PCOUT | MARIN | INCPC | ZIN, OP_ADD, 1'b1, 1'b0);
    mem_ready = 1'b0;
    repeat (2) step("ld_T1_wait", ZLOWOUT | PCIN | READ | MDRIN, OP_0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step("ld_T1", ZLOWOUT | PCIN | READ | MDRIN, OP_0, 1'b1, 1'b0);
    step("ld_T2", MDROUT | IRIN, OP_0, 1'b1, 1'b0);
    addr_calc();
    step("ld_T5", ZLOWOUT | MARIN, OP_0, 1'b1, 1'b0);
    mem_ready = 1'b0;
    repeat (3) step("ld_T6_wait", READ | MDRIN, OP_0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step("ld_T6", READ | MDRIN, OP_0, 1'b1, 1'b0);
    step("ld_T7", MDROUT | GRA_B | RIN, OP_0, 1'b1, 1'b0);

    // st with one wait cycle in T7
    ir = 32'h10000000;
    fetch(1'b0);
    addr_calc();
    step("st_T5", ZLOWOUT | MARIN, OP_0, 1'b1, 1'b0);
    step("st_T6", GRA_B | ROUT | MDRIN, OP_0, 1'b1, 1'b0);
    mem_ready = 1'b0;
    step("st_T7_wait", MDROUT | WRITE, OP_0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step("st_T7", MDROUT | WRITE, OP_0, 1'b1, 1'b0);

    // br not taken, then taken
    ir = 32'h90000000;
    for (int k = 0; k < 2; k++) begin
      CON_out = (k == 1);
      fetch(1'b0);
      step("br_T3", GRA_B | ROUT | CONIN, OP_0, 1'b1, 1'b0);
      step("br_T4", PCOUT | YIN, OP_0, 1'b1, 1'b0);
      step("br_T5", COUT | ZIN, OP_ADD, 1'b1, 1'b0);
      step(k == 1 ? "br_T6_taken" : "br_T6_not_taken",
           ZLOWOUT | (k == 1 ? PCIN : NONE), OP_0, 1'b1, 1'b0);
    end
    CON_out = 1'b0;

    // illegal opcode 11111, then nop
    ir = 32'hF8000000;
    fetch(1'b1);
    ir = 32'hD0000000;
    fetch(1'b0);

    // or (register) and andi (immediate)
    ir = 32'h30000000;
    fetch(1'b0);
    step("or_T3", GRB_B | ROUT | YIN, OP_0, 1'b1, 1'b0);
    step("or_T4", GRC_B | ROUT | ZIN, OP_OR, 1'b1, 1'b0);
    step("or_T5", ZLOWOUT | GRA_B | RIN, OP_0, 1'b1, 1'b0);
    ir = 32'h68000000;
    fetch(1'b0);
    step("andi_T3", GRB_B | ROUT | YIN, OP_0, 1'b1, 1'b0);
    step("andi_T4", COUT | ZIN, OP_AND, 1'b1, 1'b0);
    step("andi_T5", ZLOWOUT | GRA_B | RIN, OP_0, 1'b1, 1'b0);

    // sub with stop raised at T4 and released 5 cycles later
    ir = 32'h20000000;
    fetch(1'b0);
    step("sub_T3", GRB_B | ROUT | YIN, OP_0, 1'b1, 1'b0);
    stop = 1'b1;
    step("sub_T4", GRC_B | ROUT | ZIN, OP_SUB, 1'b1, 1'b0);
    step("sub_T5", ZLOWOUT | GRA_B | RIN, OP_0, 1'b1, 1'b0);
    repeat (3) step("idle", NONE, OP_0, 1'b0, 1'b0);
    stop = 1'b0;
    step("idle_release", NONE, OP_0, 1'b0, 1'b0);

    // halt with stop pending: halt wins and holds until reset
    ir = 32'hD8000000;
    step("halt_T0", PCOUT | MARIN | INCPC | ZIN, OP_ADD, 1'b1, 1'b0);
    stop = 1'b1;
    step("halt_T1", ZLOWOUT | PCIN | READ | MDRIN, OP_0, 1'b1, 1'b0);
    step("halt_T2", MDROUT | IRIN, OP_0, 1'b1, 1'b0);
    repeat (3) step("halt_hold", NONE, OP_0, 1'b0, 1'b0);
    stop = 1'b0;
    ir = 32'h10000000;
    repeat (2) step("halt_hold_st_ir", NONE, OP_0, 1'b0, 1'b0);
    Reset = 1'b1;
    step("halt_reset_edge", NONE, OP_0, 1'b0, 1'b0);
    step("halt_reset", NONE, OP_0, 1'b0, 1'b0);
    Reset = 1'b0;
    step("halt_reset_release", NONE, OP_0, 1'b0, 1'b0);

    // st aborted by reset at T6
    fetch(1'b0);
    addr_calc();
    step("st2_T5", ZLOWOUT | MARIN, OP_0, 1'b1, 1'b0);
    Reset = 1'b1;
    step("st2_T6", GRA_B | ROUT | MDRIN, OP_0, 1'b1, 1'b0);
    Reset = 1'b0;
    step("st2_aborted", NONE, OP_0, 1'b0, 1'b0);
    step("restart_T0", PCOUT | MARIN | INCPC | ZIN, OP_ADD, 1'b1, 1'b0);

    @(posedge Clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
